// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller's request/response port.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module sdram_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_avalid,
    output logic              s0_aready,
    input  logic              s0_awe,
    input  logic [ADDR_W-1:0] s0_aaddr,
    input  logic [DATA_W-1:0] s0_adata,
    output logic              s0_bvalid,
    output logic              s0_bwe,
    output logic [DATA_W-1:0] s0_bdata,
    input  logic              s1_avalid,
    output logic              s1_aready,
    input  logic              s1_awe,
    input  logic [ADDR_W-1:0] s1_aaddr,
    input  logic [DATA_W-1:0] s1_adata,
    output logic              s1_bvalid,
    output logic              s1_bwe,
    output logic [DATA_W-1:0] s1_bdata,
    output logic              m_avalid,
    input  logic              m_aready,
    output logic              m_awe,
    output logic [ADDR_W-1:0] m_aaddr,
    output logic [DATA_W-1:0] m_adata,
    input  logic              m_bvalid,
    input  logic              m_bwe,
    input  logic [DATA_W-1:0] m_bdata,
    output logic              busy,
    output logic              err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              chosen_c;
    logic              chosen_valid_c;
    logic              tag_full_c;
    logic              push_c;
    logic              pop_c;
    logic              lock_q;
    logic              lock_port_q;
    logic [DEPTH-1:0]  tag_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic              last_q;
`endif

    // Port selection: a stalled command keeps its grant until it transfers.
    always_comb begin
        chosen_c = 1'b0;
        if (lock_q) begin
            chosen_c = lock_port_q;
        end else if (s0_avalid && s1_avalid) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            chosen_c = 1'b0;
`else
            chosen_c = ~last_q;
`endif
        end else begin
            chosen_c = s1_avalid;
        end
    end

    assign tag_full_c     = (count_q == CNT_W'(DEPTH));
    assign chosen_valid_c = chosen_c ? s1_avalid : s0_avalid;
    assign m_avalid       = chosen_valid_c && !tag_full_c;
    assign m_awe          = chosen_c ? s1_awe   : s0_awe;
    assign m_aaddr        = chosen_c ? s1_aaddr : s0_aaddr;
    assign m_adata        = chosen_c ? s1_adata : s0_adata;
    assign s0_aready      = m_aready && !tag_full_c && !chosen_c && s0_avalid;
    assign s1_aready      = m_aready && !tag_full_c &&  chosen_c && s1_avalid;
    assign push_c         = m_avalid && m_aready;
    assign pop_c          = m_bvalid && (count_q != '0);
    assign busy           = (count_q != '0);

    // Tag FIFO, grant lock, round-robin state and registered response routing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b0;
`endif
            s0_bvalid   <= 1'b0;
            s0_bwe      <= 1'b0;
            s0_bdata    <= '0;
            s1_bvalid   <= 1'b0;
            s1_bwe      <= 1'b0;
            s1_bdata    <= '0;
            err         <= 1'b0;
        end else begin
            if (push_c) begin
                tag_q[wr_ptr_q] <= chosen_c;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);

            if (push_c) begin
                lock_q <= 1'b0;
            end else if (m_avalid) begin
                lock_q      <= 1'b1;
                lock_port_q <= chosen_c;
            end
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            if (push_c) begin
                last_q <= chosen_c;
            end
`endif

            s0_bvalid <= pop_c && !tag_q[rd_ptr_q];
            s1_bvalid <= pop_c &&  tag_q[rd_ptr_q];
            if (pop_c) begin
                if (tag_q[rd_ptr_q]) begin
                    s1_bwe   <= m_bwe;
                    s1_bdata <= m_bdata;
                end else begin
                    s0_bwe   <= m_bwe;
                    s0_bdata <= m_bdata;
                end
            end

            // A response with nothing outstanding is a protocol error; sticky until reset.
            if (m_bvalid && (count_q == '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: per-cycle comparison against a queue-based
// arbitration model, plus directed scenarios with literal expectations.
module tb_sdram_arbiter;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_avalid, s0_aready, s0_awe, s0_bvalid, s0_bwe;
    logic [ADDR_W-1:0] s0_aaddr;
    logic [DATA_W-1:0] s0_adata, s0_bdata;
    logic              s1_avalid, s1_aready, s1_awe, s1_bvalid, s1_bwe;
    logic [ADDR_W-1:0] s1_aaddr;
    logic [DATA_W-1:0] s1_adata, s1_bdata;
    logic              m_avalid, m_aready, m_awe, m_bvalid, m_bwe;
    logic [ADDR_W-1:0] m_aaddr;
    logic [DATA_W-1:0] m_adata, m_bdata;
    logic              busy, err;

    sdram_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .s0_avalid(s0_avalid), .s0_aready(s0_aready), .s0_awe(s0_awe),
        .s0_aaddr(s0_aaddr), .s0_adata(s0_adata),
        .s0_bvalid(s0_bvalid), .s0_bwe(s0_bwe), .s0_bdata(s0_bdata),
        .s1_avalid(s1_avalid), .s1_aready(s1_aready), .s1_awe(s1_awe),
        .s1_aaddr(s1_aaddr), .s1_adata(s1_adata),
        .s1_bvalid(s1_bvalid), .s1_bwe(s1_bwe), .s1_bdata(s1_bdata),
        .m_avalid(m_avalid), .m_aready(m_aready), .m_awe(m_awe),
        .m_aaddr(m_aaddr), .m_adata(m_adata),
        .m_bvalid(m_bvalid), .m_bwe(m_bwe), .m_bdata(m_bdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding commands as a queue of issuing ports.
    bit              m_last, m_stall, m_stall_port;
    bit              tagq[$];
    bit              awe_log[$];
    bit              e_bv0, e_bv1, e_bwe, e_err;
    logic [DATA_W-1:0] e_bdata;
    bit              acc0, acc1;
    bit              ch, v0, v1, cv, full, emav, xfer, head;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_s0_bvalid", 32'(s0_bvalid), 32'd0);
            chk("rst_s1_bvalid", 32'(s1_bvalid), 32'd0);
            chk("rst_s0_bwe",    32'(s0_bwe),    32'd0);
            chk("rst_s1_bwe",    32'(s1_bwe),    32'd0);
            chk("rst_s0_bdata",  32'(s0_bdata),  32'd0);
            chk("rst_s1_bdata",  32'(s1_bdata),  32'd0);
            chk("rst_busy",      32'(busy),      32'd0);
            chk("rst_err",       32'(err),       32'd0);
            m_last = 1'b0; m_stall = 1'b0; tagq.delete();
            e_bv0 = 1'b0; e_bv1 = 1'b0; e_err = 1'b0;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            chk("s0_bvalid", 32'(s0_bvalid), 32'(e_bv0));
            chk("s1_bvalid", 32'(s1_bvalid), 32'(e_bv1));
            if (e_bv0) begin
                chk("s0_bwe",   32'(s0_bwe),   32'(e_bwe));
                chk("s0_bdata", 32'(s0_bdata), 32'(e_bdata));
            end
            if (e_bv1) begin
                chk("s1_bwe",   32'(s1_bwe),   32'(e_bwe));
                chk("s1_bdata", 32'(s1_bdata), 32'(e_bdata));
            end
            chk("err",  32'(err),  32'(e_err));
            chk("busy", 32'(busy), 32'(tagq.size() != 0));

            v0 = s0_avalid; v1 = s1_avalid;
            if (m_stall)        ch = m_stall_port;
            else if (v0 && v1)  ch = FIXED ? 1'b0 : !m_last;
            else                ch = v1;
            cv   = ch ? v1 : v0;
            full = (tagq.size() == DEPTH);
            emav = cv && !full;
            chk("m_avalid",  32'(m_avalid),  32'(emav));
            chk("s0_aready", 32'(s0_aready), 32'(m_aready && !full && !ch && v0));
            chk("s1_aready", 32'(s1_aready), 32'(m_aready && !full && ch && v1));
            if (emav) begin
                chk("m_awe",   32'(m_awe),   32'(ch ? s1_awe   : s0_awe));
                chk("m_aaddr", 32'(m_aaddr), 32'(ch ? s1_aaddr : s0_aaddr));
                chk("m_adata", 32'(m_adata), 32'(ch ? s1_adata : s0_adata));
            end
            xfer = emav && m_aready;

            e_bv0 = 1'b0; e_bv1 = 1'b0;
            if (m_bvalid) begin
                if (tagq.size() == 0) begin
                    e_err = 1'b1;
                end else begin
                    head = tagq.pop_front();
                    e_bv0 = !head; e_bv1 = head;
                    e_bwe = m_bwe; e_bdata = m_bdata;
                end
            end
            if (xfer) begin
                tagq.push_back(ch);
                awe_log.push_back(ch ? s1_awe : s0_awe);
                m_last  = ch;
                m_stall = 1'b0;
            end else if (emav) begin
                m_stall = 1'b1;
                m_stall_port = ch;
            end
            acc0 = xfer && !ch;
            acc1 = xfer && ch;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    logic [ADDR_W-1:0] ga[4];
    bit                gp[4];
    logic [DATA_W-1:0] rd_data[4];
    int                ctrl_rd;

    initial begin
        rst = 1'b1;
        s0_avalid = 0; s0_awe = 0; s0_aaddr = '0; s0_adata = '0;
        s1_avalid = 0; s1_awe = 0; s1_aaddr = '0; s1_adata = '0;
        m_aready = 0; m_bvalid = 0; m_bwe = 0; m_bdata = '0;
        rd_data[0] = 16'h1111; rd_data[1] = 16'h2222;
        rd_data[2] = 16'h3333; rd_data[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            gp[i] = FIXED ? 1'b0 : i[0];
            ga[i] = gp[i] ? 24'h000200 : 24'h000100;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Port 0 write, ack routed back to port 0.
        tick(); s0_avalid = 1; s0_awe = 1; s0_aaddr = 24'h000010; s0_adata = 16'hBEEF; m_aready = 1;
        mid();  chk("t1_m_avalid", 32'(m_avalid), 32'd1);
                chk("t1_m_awe",    32'(m_awe),    32'd1);
                chk("t1_m_aaddr",  32'(m_aaddr),  32'h10);
                chk("t1_m_adata",  32'(m_adata),  32'hBEEF);
        tick(); s0_avalid = 0; m_bvalid = 1; m_bwe = 1; m_bdata = 16'h0;
        mid();  chk("t1_latency", 32'(s0_bvalid), 32'd0);
        tick(); m_bvalid = 0;
        mid();  chk("t1_s0_bvalid", 32'(s0_bvalid), 32'd1);
                chk("t1_s0_bwe",    32'(s0_bwe),    32'd1);
                chk("t1_s1_bvalid", 32'(s1_bvalid), 32'd0);

        // Port 1 read so port 1 is the last grant.
        tick(); s1_avalid = 1; s1_awe = 0; s1_aaddr = 24'h000020; m_aready = 1;
        mid();  chk("t1b_s1_aready", 32'(s1_aready), 32'd1);
        tick(); s1_avalid = 0; m_bvalid = 1; m_bwe = 0; m_bdata = 16'h5555;
        tick(); m_bvalid = 0;
        mid();  chk("t1b_s1_bdata", 32'(s1_bdata), 32'h5555);

        // Both ports continuously valid: grants alternate.
        tick(); s0_avalid = 1; s0_awe = 0; s0_aaddr = 24'h000100;
                s1_avalid = 1; s1_awe = 0; s1_aaddr = 24'h000200;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("t2_grant", 32'(m_aaddr), 32'(ga[i]));
            tick();
        end
        s0_avalid = 0; s1_avalid = 0; m_bvalid = 1; m_bwe = 0; m_bdata = rd_data[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) m_bdata = rd_data[i+1];
            else       m_bvalid = 0;
            mid();
            chk("t2_bvalid", 32'(gp[i] ? s1_bvalid : s0_bvalid), 32'd1);
            chk("t2_other",  32'(gp[i] ? s0_bvalid : s1_bvalid), 32'd0);
            chk("t2_bdata",  32'(gp[i] ? s1_bdata  : s0_bdata),  32'(rd_data[i]));
            tick();
        end

        // Stalled port 1 keeps its grant even when port 0 would win.
        s1_avalid = 1; s1_aaddr = 24'h000300; m_aready = 0;
        mid();  chk("t3_stall1", 32'(m_aaddr), 32'h300);
        tick(); s0_avalid = 1; s0_aaddr = 24'h000400;
        mid();  chk("t3_stall2", 32'(m_aaddr), 32'h300);
        tick();
        mid();  chk("t3_stall3", 32'(m_aaddr), 32'h300);
        tick(); m_aready = 1;
        mid();  chk("t3_accept1", 32'(s1_aready), 32'd1);
        tick(); s1_avalid = 0;
        mid();  chk("t3_next", 32'(m_aaddr), 32'h400);
        tick(); s0_avalid = 0; m_bvalid = 1;
        tick(); tick(); m_bvalid = 0;

        // Fill the tag FIFO, then release one slot.
        s0_avalid = 1; s0_aaddr = 24'h000500;
        repeat (4) tick();
        s1_avalid = 1; s1_aaddr = 24'h000600;
        mid();  chk("t4_full_mav", 32'(m_avalid),  32'd0);
                chk("t4_full_r0",  32'(s0_aready), 32'd0);
                chk("t4_full_r1",  32'(s1_aready), 32'd0);
                chk("t4_full_busy", 32'(busy),     32'd1);
        tick(); m_bvalid = 1; m_bdata = 16'h0A0A;
        mid();  chk("t4_pop_cycle", 32'(m_avalid), 32'd0);
        tick(); m_bvalid = 0;
        mid();  chk("t4_resume", 32'(m_avalid), 32'd1);
        tick(); s0_avalid = 0; s1_avalid = 0; m_bvalid = 1;
        repeat (4) tick();
        m_bvalid = 0;
        mid();  chk("t4_drained", 32'(busy), 32'd0);

        // Stray response sets err; reset clears it.
        tick(); m_bvalid = 1; m_bdata = 16'h0077;
        tick(); m_bvalid = 0;
        mid();  chk("t5_err", 32'(err), 32'd1);
                chk("t5_no_b0", 32'(s0_bvalid), 32'd0);
                chk("t5_no_b1", 32'(s1_bvalid), 32'd0);
        tick(); rst = 1;
        mid();  chk("t5_err_clr", 32'(err), 32'd0);
        tick(); rst = 0;
        ctrl_rd = awe_log.size();

        // Randomized traffic with one mid-run reset.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (cyc == 2000) begin
                rst = 1; s0_avalid = 0; s1_avalid = 0; m_bvalid = 0;
                continue;
            end
            if (cyc == 2001) begin
                rst = 0;
                ctrl_rd = awe_log.size();
            end
            if (!s0_avalid || acc0) begin
                s0_avalid = ($urandom_range(0, 99) < 60);
                s0_awe    = 1'($urandom);
                s0_aaddr  = ADDR_W'($urandom);
                s0_adata  = DATA_W'($urandom);
            end
            if (!s1_avalid || acc1) begin
                s1_avalid = ($urandom_range(0, 99) < 60);
                s1_awe    = 1'($urandom);
                s1_aaddr  = ADDR_W'($urandom);
                s1_adata  = DATA_W'($urandom);
            end
            m_aready = ($urandom_range(0, 99) < 75);
            m_bdata  = DATA_W'($urandom);
            if (ctrl_rd < awe_log.size() && $urandom_range(0, 99) < 55) begin
                m_bvalid = 1;
                m_bwe    = awe_log[ctrl_rd];
                ctrl_rd++;
            end else begin
                m_bvalid = 0;
            end
        end
        tick(); s0_avalid = 0; s1_avalid = 0; m_bvalid = 0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single request/response port of the SDRAM controller between two requesters (port 0: USB/host access, port 1: sampler stream). Picks one requester per accepted command and forwards it unchanged. Records the issuing port in an in-order tag FIFO. Routes each controller response (read data or write ack) back to the port that issued it. Sits directly between the requesters and the SDRAM controller's a/b ports.

Parameters:
DEPTH, 4, max outstanding (accepted, not yet responded) commands; power of two, 2..16
ADDR_W, 24, address width, matches controller
DATA_W, 16, data width, matches controller

Ports:
clk  in  1  system clock
rst  in  1  reset
s0_avalid / s1_avalid  in  1  request valid, port 0 / port 1
s0_aready / s1_aready  out  1  request accepted this cycle
s0_awe / s1_awe  in  1  1=write, 0=read
s0_aaddr / s1_aaddr  in  ADDR_W  word address
s0_adata / s1_adata  in  DATA_W  write data
s0_bvalid / s1_bvalid  out  1  response valid
s0_bwe / s1_bwe  out  1  response kind: 1=write ack, 0=read data
s0_bdata / s1_bdata  out  DATA_W  read data; undefined for write ack
m_avalid  out  1  to controller avalid
m_aready  in  1  from controller aready
m_awe, m_aaddr, m_adata  out  1/ADDR_W/DATA_W  to controller
m_bvalid, m_bwe, m_bdata  in  1/1/DATA_W  from controller
busy  out  1  outstanding count != 0
err  out  1  sticky: m_bvalid received with tag FIFO empty

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values: sN_bvalid=0, sN_bwe=0, sN_bdata=0, busy=0, err=0, tag FIFO empty, rr pointer=port 0, grant lock clear.
- Accept rule: a command transfers on m_avalid && m_aready. m_avalid = (chosen port valid) && !tag_full. A tag push is allowed in the same cycle as a pop (count unchanged).
- Selection (combinational, round-robin): if exactly one port valid, choose it. If both are valid, choose the port != last-granted. After a transfer, last-granted <= chosen port.
- Grant lock: if m_avalid=1 and m_aready=0, latch the chosen port. It stays chosen on following cycles until its transfer completes, even if the other port becomes the round-robin winner. m_awe/m_aaddr/m_adata are therefore stable while stalled. Requesters must hold valid and payload until aready.
- sN_aready = m_aready && !tag_full && (chosen==N) && sN_avalid. This is combinational and contains no path from sN_avalid to m_aready.
- Tag FIFO: DEPTH entries of 1 bit (port id). Push on transfer. Pop on m_bvalid. Count is $clog2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.
- Response routing: registered, 1-cycle latency. On m_bvalid with head tag N: next cycle sN_bvalid=1, sN_bwe=m_bwe, sN_bdata=m_bdata; the other port's bvalid=0. At most one sN_bvalid is high per cycle. Back-to-back responses produce back-to-back pulses.
- Responses arrive in command order, one per accepted command. The earliest response is one cycle after acceptance, so a push and a pop of the same entry never happen in the same cycle.
- Full: when count==DEPTH, m_avalid=0 and both aready=0. A pop in that cycle does not re-enable issue until the next cycle.
- Empty with m_bvalid: no pop, no sN_bvalid, err<=1 (cleared only by rst).
- Reset mid-operation: all outstanding tags are discarded. Any later stray responses from the controller set err.

Optional Feature:
Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both ports are valid. The round-robin pointer is not implemented. The grant lock still applies, so a stalled port-1 command is not pre-empted.
- Undefined: round-robin as above.

Test Plan:
- Port 0 writes addr 0x000010 data 0xBEEF with m_aready=1 -> m_awe=1, m_aaddr=0x000010. One cycle after controller bvalid/bwe=1: s0_bvalid=1, s0_bwe=1, s1_bvalid stays 0.
- Both ports hold reads for 4 cycles, m_aready=1 -> grants alternate 0,1,0,1. Controller returns reads 0x1111,0x2222,0x3333,0x4444 -> s0 gets 0x1111 and 0x3333, s1 gets 0x2222 and 0x4444, in order.
- Port 1 valid, m_aready=0 for 3 cycles, port 0 raises valid in cycle 2 -> m_aaddr stays port 1's address until accepted. Port 0 is granted next.
- DEPTH=4, 4 reads accepted, no responses -> m_avalid=0, both aready=0, busy=1. One response -> issue resumes in the following cycle.
- m_bvalid pulse with nothing outstanding -> err=1, no sN_bvalid. Assert rst -> err=0.
- With SDRAM_ARB_FIXED_PRIO_EN, both ports continuously valid -> port 0 is granted every transfer; port 1 only when port 0 drops valid.
